// File: rtl/edge_event_arbiter.sv
// Rising-edge event collector: detects rising edges on N level inputs, queues one
// pending event per channel, and reports them round-robin through a one-deep output stage.
module edge_event_arbiter #(
    parameter int N  = 4,
    parameter int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  a,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_chan,
    output logic [N-1:0]  ovf,
    input  logic          ovf_clr
);

    logic [N-1:0]  a_r;
    logic [N-1:0]  pending;
    logic [CW-1:0] last_grant;

    logic [N-1:0]  rise;
    logic          free;
    logic          found;
    logic [CW-1:0] win;
    logic          load;
    logic [N-1:0]  clear_mask;
    logic [N-1:0]  pending_next;
    logic [N-1:0]  ovf_set;

    assign rise = a & ~a_r;
    assign free = ~out_valid | out_ready;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_grant) + k) % N;
            if (!found && pending[idx]) begin
                found = 1'b1;
                win   = CW'(idx);
            end
        end
    end

    assign load       = free & found;
    assign clear_mask = load ? (N'(1) << win) : '0;

    // A fresh edge on the channel being granted this cycle survives as a new event.
    assign pending_next = (pending & ~clear_mask) | rise;
    assign ovf_set      = rise & pending & ~clear_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r        <= '0;
            pending    <= '0;
            out_valid  <= 1'b0;
            out_chan   <= '0;
            ovf        <= '0;
            last_grant <= CW'(N - 1);
        end else begin
            a_r     <= a;
            pending <= pending_next;
            ovf     <= (ovf_clr ? '0 : ovf) | ovf_set;
            if (load) begin
                out_valid  <= 1'b1;
                out_chan   <= win;
                last_grant <= win;
            end else if (free) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench for edge_event_arbiter: directed vector table followed by
// randomized traffic checked against a cycle-level reference model.
module tb_edge_event_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_chan;
    logic [3:0] ovf;
    logic       ovf_clr;

    int passed;
    int total;

    typedef struct {
        logic       rst;
        logic [3:0] a;
        logic       rdy;
        logic       clr;
        logic       ev;
        logic [1:0] ech;
        logic [3:0] eovf;
    } vec_t;

    typedef struct {
        logic       v;
        logic [1:0] ch;
        logic       chk_ch;
        logic [3:0] ov;
        int         tag;
    } exp_t;

    vec_t vecs[$];
    exp_t scoreboard[$];

    // Reference model state
    logic [3:0] m_ar;
    logic [3:0] m_pend;
    logic       m_valid;
    logic [1:0] m_chan;
    logic [3:0] m_ovf;
    int         m_last;

    edge_event_arbiter #(.N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [3:0] av, input logic rdy,
                                input logic clr, input logic ev, input logic [1:0] ech,
                                input logic [3:0] eovf);
        vec_t v;
        v.rst = r; v.a = av; v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.ech = ech; v.eovf = eovf;
        return v;
    endfunction

    task automatic model_step(input logic r, input logic [3:0] av, input logic rdy,
                              input logic clr);
        logic [3:0] e;
        logic [3:0] np;
        logic [3:0] no;
        int         w;
        int         c;
        if (r) begin
            m_ar = 4'b0; m_pend = 4'b0; m_valid = 1'b0; m_chan = 2'd0;
            m_ovf = 4'b0; m_last = 3;
            return;
        end
        e  = av & ~m_ar;
        np = m_pend;
        no = clr ? 4'b0 : m_ovf;
        w  = -1;
        if (!m_valid || rdy) begin
            for (int k = 1; k <= 4; k++) begin
                c = (m_last + k) % 4;
                if (w < 0 && m_pend[c]) w = c;
            end
            if (w >= 0) begin
                np[w]   = 1'b0;
                m_valid = 1'b1;
                m_chan  = 2'(w);
                m_last  = w;
            end else begin
                m_valid = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (e[i]) begin
                if (m_pend[i] && i != w) no[i] = 1'b1;
                np[i] = 1'b1;
            end
        end
        m_pend = np;
        m_ovf  = no;
        m_ar   = av;
    endtask

    task automatic checkOutput();
        exp_t x;
        if (scoreboard.size() == 0) begin
            total++;
            $display("[TB] FAIL scoreboard_empty: actual size 0, required >= 1");
            return;
        end
        x = scoreboard.pop_front();
        total++;
        if (out_valid === x.v) passed++;
        else $display("[TB] FAIL out_valid step %0d: actual %b, required %b", x.tag, out_valid, x.v);
        total++;
        if (ovf === x.ov) passed++;
        else $display("[TB] FAIL ovf step %0d: actual %b, required %b", x.tag, ovf, x.ov);
        if (x.chk_ch) begin
            total++;
            if (out_chan === x.ch) passed++;
            else $display("[TB] FAIL out_chan step %0d: actual %0d, required %0d", x.tag, out_chan, x.ch);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] av, input logic rdy,
                                 input logic clr, input exp_t x);
        @(negedge clk);
        rst       = r;
        a         = av;
        out_ready = rdy;
        ovf_clr   = clr;
        scoreboard.push_back(x);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        exp_t x;
        logic       r_rst;
        logic [3:0] r_a;
        logic       r_rdy;
        logic       r_clr;

        passed = 0; total = 0;
        rst = 1'b1; a = 4'b0; out_ready = 1'b0; ovf_clr = 1'b0;

        // Single edge on channel 0
        vecs.push_back(mk(1, 4'h0, 1, 0, 0, 0, 4'h0));
        vecs.push_back(mk(0, 4'h0, 1, 0, 0, 0, 4'h0));
        vecs.push_back(mk(0, 4'h1, 1, 0, 0, 0, 4'h0));
        vecs.push_back(mk(0, 4'h1, 1, 0, 1, 0, 4'h0));
        vecs.push_back(mk(0, 4'h1, 1, 0, 0, 0, 4'h0));
        vecs.push_back(mk(0, 4'h1, 1, 0, 0, 0, 4'h0));
        // All channels rise together
        vecs.push_back(mk(1, 4'h0, 1, 0, 0, 0, 4'h0));
        vecs.push_back(mk(0, 4'hF, 1, 0, 0, 0, 4'h0));
        vecs.push_back(mk(0, 4'hF, 1, 0, 1, 0, 4'h0));
        vecs.push_back(mk(0, 4'hF, 1, 0, 1, 1, 4'h0));
        vecs.push_back(mk(0, 4'hF, 1, 0, 1, 2, 4'h0));
        vecs.push_back(mk(0, 4'hF, 1, 0, 1, 3, 4'h0));
        vecs.push_back(mk(0, 4'hF, 1, 0, 0, 0, 4'h0));
        // Backpressure on channels 1 and 2
        vecs.push_back(mk(1, 4'h0, 0, 0, 0, 0, 4'h0));
        vecs.push_back(mk(0, 4'h6, 0, 0, 0, 0, 4'h0));
        vecs.push_back(mk(0, 4'h6, 0, 0, 1, 1, 4'h0));
        vecs.push_back(mk(0, 4'h6, 0, 0, 1, 1, 4'h0));
        vecs.push_back(mk(0, 4'h6, 0, 0, 1, 1, 4'h0));
        vecs.push_back(mk(0, 4'h6, 1, 0, 1, 2, 4'h0));
        vecs.push_back(mk(0, 4'h6, 1, 0, 0, 0, 4'h0));
        // Overflow on channel 3, clear losing to a simultaneous overflow, then clearing
        vecs.push_back(mk(1, 4'h0, 0, 0, 0, 0, 4'h0));
        vecs.push_back(mk(0, 4'h8, 0, 0, 0, 0, 4'h0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 1, 3, 4'h0));
        vecs.push_back(mk(0, 4'h8, 0, 0, 1, 3, 4'h0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 1, 3, 4'h0));
        vecs.push_back(mk(0, 4'h8, 0, 0, 1, 3, 4'h8));
        vecs.push_back(mk(0, 4'h0, 0, 0, 1, 3, 4'h8));
        vecs.push_back(mk(0, 4'h8, 0, 1, 1, 3, 4'h8));
        vecs.push_back(mk(0, 4'h0, 0, 1, 1, 3, 4'h0));
        vecs.push_back(mk(0, 4'h0, 1, 0, 1, 3, 4'h0));
        vecs.push_back(mk(0, 4'h0, 1, 0, 0, 0, 4'h0));
        // Fairness between channels 0 and 1
        vecs.push_back(mk(1, 4'h0, 1, 0, 0, 0, 4'h0));
        vecs.push_back(mk(0, 4'h3, 1, 0, 0, 0, 4'h0));
        vecs.push_back(mk(0, 4'h0, 1, 0, 1, 0, 4'h0));
        vecs.push_back(mk(0, 4'h3, 1, 0, 1, 1, 4'h0));
        vecs.push_back(mk(0, 4'h0, 1, 0, 1, 0, 4'h0));
        vecs.push_back(mk(0, 4'h3, 1, 0, 1, 1, 4'h0));
        vecs.push_back(mk(0, 4'h0, 1, 0, 1, 0, 4'h0));
        vecs.push_back(mk(0, 4'h0, 1, 0, 1, 1, 4'h0));
        vecs.push_back(mk(0, 4'h0, 1, 0, 0, 0, 4'h0));
        // Reset with traffic in flight; channel 2 held high through reset
        vecs.push_back(mk(1, 4'h0, 0, 0, 0, 0, 4'h0));
        vecs.push_back(mk(0, 4'hF, 0, 0, 0, 0, 4'h0));
        vecs.push_back(mk(0, 4'hF, 0, 0, 1, 0, 4'h0));
        vecs.push_back(mk(1, 4'h4, 0, 0, 0, 0, 4'h0));
        vecs.push_back(mk(1, 4'h4, 0, 0, 0, 0, 4'h0));
        vecs.push_back(mk(0, 4'h4, 1, 0, 0, 0, 4'h0));
        vecs.push_back(mk(0, 4'h4, 1, 0, 1, 2, 4'h0));
        vecs.push_back(mk(0, 4'h4, 1, 0, 0, 0, 4'h0));

        foreach (vecs[i]) begin
            x.v      = vecs[i].ev;
            x.ch     = vecs[i].ech;
            x.chk_ch = vecs[i].ev | vecs[i].rst;
            x.ov     = vecs[i].eovf;
            x.tag    = i;
            applyStimulus(vecs[i].rst, vecs[i].a, vecs[i].rdy, vecs[i].clr, x);
        end
        $display("[TB] directed table done, %0d vectors", vecs.size());

        // Randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            r_rst = (n == 0) || ($urandom_range(0, 99) == 0);
            r_a   = 4'($urandom_range(0, 15));
            r_rdy = ($urandom_range(0, 3) != 0);
            r_clr = ($urandom_range(0, 15) == 0);
            model_step(r_rst, r_a, r_rdy, r_clr);
            x.v      = m_valid;
            x.ch     = m_chan;
            x.chk_ch = m_valid | r_rst;
            x.ov     = m_ovf;
            x.tag    = 1000 + n;
            applyStimulus(r_rst, r_a, r_rdy, r_clr, x);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/edge_event_arbiter.md
EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 Parameter: N, default 4, number of input channels (2..16).
REQ-002 Parameter: CW, default $clog2(N), channel index width.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 a  input  N  asynchronous-free level inputs, one per channel, sampled each clk.
REQ-006 out_valid  output  1  event available on out_chan.
REQ-007 out_ready  input  1  consumer accepts the event when high with out_valid.
REQ-008 out_chan  output  CW  index of the channel whose rising edge is being reported.
REQ-009 ovf  output  N  sticky per-channel overflow flags.
REQ-010 ovf_clr  input  1  one-cycle pulse; clears all ovf bits.

Function
REQ-011 Per channel i, the block SHALL register a[i] into a_r[i] every cycle and detect edge[i] = a[i] & ~a_r[i] (combinational, same cycle).
REQ-012 edge[i] SHALL set pending[i] at the next posedge.
REQ-013 An edge[i] while pending[i] is already 1 and not being cleared that cycle SHALL leave pending[i] = 1 and set ovf[i] (event dropped, coalesced).
REQ-014 The output stage SHALL be a single register (out_valid, out_chan); it is "free" when out_valid = 0 or out_valid & out_ready.
REQ-015 When the output stage is free and any pending bit is set, the block SHALL load the winning channel into out_chan, set out_valid, and clear that pending bit at the same posedge.
REQ-016 When free and no pending bit is set, out_valid SHALL go to 0 at the posedge.
REQ-017 When not free (out_valid & ~out_ready), out_valid and out_chan SHALL hold unchanged.
REQ-018 Winner selection SHALL be round-robin: search starts at last_grant+1 modulo N, first pending channel wins; last_grant updates to the winner on each load.
REQ-019 edge[i] in the same cycle pending[i] is cleared by a load SHALL leave pending[i] = 1 (new event kept), no ovf.
REQ-020 An edge on a channel whose previous event is held in the output stage SHALL set pending normally; no ovf.
REQ-021 Latency: a[i] rising sampled at posedge t -> pending at t -> out_valid high after t+1 if the stage is free and channel i wins.
REQ-022 ovf_clr SHALL clear all ovf bits at the posedge; a simultaneous new overflow on channel i SHALL leave ovf[i] = 1 (set wins).
REQ-023 Steady-state throughput SHALL be one event per cycle while out_ready = 1 and events are pending.

Reset
REQ-024 While rst = 1: a_r = 0, pending = 0, out_valid = 0, out_chan = 0, ovf = 0, last_grant = N-1 (channel 0 has first priority).
REQ-025 Reset mid-operation SHALL discard all pending and in-flight events; no event is reported for edges sampled during reset.
REQ-026 A channel already high in the first cycle after rst deasserts SHALL be reported as a rising edge (a_r = 0 from reset).

Verification
REQ-027 Single edge: a = 0001 from 0000, out_ready = 1 -> out_valid high 2 cycles after sampling for exactly 1 cycle, out_chan = 0.
REQ-028 Simultaneous edges: a 0000 -> 1111, out_ready = 1 -> out_chan sequence 0,1,2,3 on consecutive cycles, ovf = 0000.
REQ-029 Backpressure: out_ready = 0 with events on channels 1 and 2 -> out_valid/out_chan = 1 held stable; on out_ready = 1 -> 1 then 2 transferred.
REQ-030 Overflow: out_ready = 0, channel 3 toggled 0->1->0->1 twice -> ovf[3] = 1, only one channel-3 event delivered after a channel-3 event already in stage; ovf_clr -> ovf = 0000.
REQ-031 Fairness: channels 0 and 1 pulsing every cycle-pair, out_ready = 1 -> grants alternate 0,1,0,1, no starvation.
REQ-032 Reset: rst asserted with out_valid = 1 and pending bits set -> all outputs 0 next cycle; a held at 0100 through reset -> channel 2 reported after release.
